// File: rtl/cmos_rgb565_pack_if.sv
// ---------------------------------------------------------------------------
// cmos_rgb565_pack_if
//   Bundles the OV5640 DVP byte stream and the packed RGB565 write port of
//   cmos_rgb565_pack.
//
//   cmos_vsync  camera vertical sync
//   cmos_href   camera line valid, high during active bytes
//   cmos_d      camera data byte
//   pix_we      one-cycle write strobe for pix_data
//   pix_data    RGB565 word, first byte of the pair in [15:8]
//
//   master : the side that drives the camera bytes and consumes the words
//   slave  : the packer (cmos_rgb565_pack)
// ---------------------------------------------------------------------------
interface cmos_rgb565_pack_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_d;
  logic        pix_we;
  logic [15:0] pix_data;

  modport master (
    output cmos_vsync, cmos_href, cmos_d,
    input  pix_we, pix_data
  );

  modport slave (
    input  cmos_vsync, cmos_href, cmos_d,
    output pix_we, pix_data
  );
endinterface

// File: rtl/cmos_rgb565_pack.sv
// ---------------------------------------------------------------------------
// cmos_rgb565_pack
//   Capture front-end between the camera source mux and the SDRAM write FIFO.
//   Packs the 8-bit DVP byte stream into 16-bit RGB565 words with a write
//   strobe, holds output off until init is done and SKIP_FRAMES warm-up
//   frames have been discarded, and reports frame-valid, frame-start,
//   line-length error and frames-per-second status. Single clock domain
//   (camera pixel clock), synchronous active-high reset.
//
//   Optional build macro CMOS_PACK_TESTPAT_EN: replaces the packed camera
//   data with 8 vertical colour bars (strobe timing unchanged).
//
// Ports:
//   clk          camera pixel clock, rising edge
//   rst          synchronous active-high reset
//   init_done    camera config done AND sdram init done (level)
//   sec_tick     one-cycle pulse once per second
//   cam          camera byte stream in / packed word out (slave modport)
//   frame_valid  high while output is enabled
//   frame_start  one-cycle pulse at each counted frame boundary
//   line_err     sticky line-length / odd-byte error
//   fps          frames counted in the previous sec_tick period
// ---------------------------------------------------------------------------
module cmos_rgb565_pack #(
  parameter int unsigned SKIP_FRAMES = 10,
  parameter bit          VSYNC_POL   = 1'b1,
  parameter int unsigned H_PIXELS    = 1024,
  parameter int unsigned FPS_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  input  logic               sec_tick,
  cmos_rgb565_pack_if.slave  cam,
  output logic               frame_valid,
  output logic               frame_start,
  output logic               line_err,
  output logic [FPS_W-1:0]   fps
);

  localparam int unsigned SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  // One spare bit so over-long lines cannot wrap back onto H_PIXELS.
  localparam int unsigned LINE_W = $clog2(H_PIXELS + 1) + 1;

  typedef enum logic [1:0] {
    WAIT_INIT,
    SKIP,
    WAIT_VS,
    ACTIVE
  } state_t;

  state_t              state, state_nx;

  logic                vs_r, vs_rr;
  logic                hr_r, hr_rr;
  logic [7:0]          d_r;

  logic                boundary;
  logic                line_end;
  logic                pack_en;
  logic                fs_nx;

  logic [SKIP_W-1:0]   skip_cnt;

  logic                phase;
  logic [7:0]          hi;
  logic [LINE_W-1:0]   line_cnt;
  logic                pix_we_q;
  logic [15:0]         pix_data_q;
  logic [15:0]         word_nx;

  logic [FPS_W-1:0]    frame_cnt;
  logic [FPS_W-1:0]    frame_inc;
  logic                cnt_en;

  // -------------------------------------------------------------------------
  // Input stage. vsync registers reset to the inactive level so that leaving
  // reset can never look like the end of a vsync pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r  <= ~VSYNC_POL;
      vs_rr <= ~VSYNC_POL;
      hr_r  <= 1'b0;
      hr_rr <= 1'b0;
      d_r   <= '0;
    end else begin
      vs_r  <= cam.cmos_vsync;
      vs_rr <= vs_r;
      hr_r  <= cam.cmos_href;
      hr_rr <= hr_r;
      d_r   <= cam.cmos_d;
    end
  end

  // End of the vsync pulse marks a frame boundary.
  assign boundary = (vs_rr == VSYNC_POL) && (vs_r != VSYNC_POL);
  assign line_end = hr_rr && !hr_r;

  // init_done is folded in so a pair whose second byte lands in the cycle
  // init_done drops is discarded rather than strobed.
  assign pack_en  = (state == ACTIVE) && init_done;

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_INIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fs_nx    = 1'b0;
    case (state)
      WAIT_INIT: begin
        if (init_done) begin
          state_nx = (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
        end
      end
      SKIP: begin
        // skip_cnt reaches zero on this boundary
        if (boundary && (skip_cnt <= SKIP_W'(1))) begin
          state_nx = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (boundary) begin
          state_nx = ACTIVE;
          fs_nx    = 1'b1;
        end
      end
      ACTIVE: begin
        fs_nx = boundary;
      end
      default: state_nx = WAIT_INIT;
    endcase
    if (!init_done) begin
      state_nx = WAIT_INIT;
      fs_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_valid <= (state_nx == ACTIVE);
      frame_start <= fs_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt <= '0;
    end else if ((state == WAIT_INIT) && init_done) begin
      skip_cnt <= SKIP_W'(SKIP_FRAMES);
    end else if ((state == SKIP) && boundary && (skip_cnt != '0)) begin
      skip_cnt <= skip_cnt - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Word source: camera bytes, or colour bars indexed by pixel-in-line.
  // -------------------------------------------------------------------------
`ifdef CMOS_PACK_TESTPAT_EN
  localparam int unsigned LOG2_H = $clog2(H_PIXELS);

  logic [2:0] bar_idx;
  assign bar_idx = line_cnt[LOG2_H-1 -: 3];

  always_comb begin
    word_nx = '0;
    case (bar_idx)
      3'd0:    word_nx = 16'hFFFF;  // white
      3'd1:    word_nx = 16'hFFE0;  // yellow
      3'd2:    word_nx = 16'h07FF;  // cyan
      3'd3:    word_nx = 16'h07E0;  // green
      3'd4:    word_nx = 16'hF81F;  // magenta
      3'd5:    word_nx = 16'hF800;  // red
      3'd6:    word_nx = 16'h001F;  // blue
      default: word_nx = 16'h0000;  // black
    endcase
  end
`else
  assign word_nx = {hi, d_r};
`endif

  // -------------------------------------------------------------------------
  // Byte packing and line-length check
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= 1'b0;
      hi         <= '0;
      pix_we_q   <= 1'b0;
      pix_data_q <= '0;
      line_cnt   <= '0;
      line_err   <= 1'b0;
    end else begin
      pix_we_q <= 1'b0;

      if (pack_en && hr_r) begin
        if (!phase) begin
          hi    <= d_r;
          phase <= 1'b1;
        end else begin
          phase      <= 1'b0;
          pix_we_q   <= 1'b1;
          pix_data_q <= word_nx;
          if (line_cnt != '1) begin
            line_cnt <= line_cnt + 1'b1;
          end
        end
      end else begin
        phase <= 1'b0;
      end

      // line_cnt already includes the final strobe and phase still shows a
      // dangling byte in the first cycle after href falls.
      if (pack_en && line_end) begin
        if ((line_cnt != LINE_W'(H_PIXELS)) || phase) begin
          line_err <= 1'b1;
        end
        line_cnt <= '0;
      end else if (!pack_en) begin
        line_cnt <= '0;
      end
    end
  end

  assign cam.pix_we   = pix_we_q;
  assign cam.pix_data = pix_data_q;

  // -------------------------------------------------------------------------
  // Frames per second
  // -------------------------------------------------------------------------
  assign cnt_en    = boundary && (state != WAIT_INIT);
  assign frame_inc = (cnt_en && (frame_cnt != '1)) ? frame_cnt + 1'b1 : frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      fps       <= '0;
    end else if (sec_tick) begin
      fps       <= frame_inc;
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_inc;
    end
  end

endmodule

// File: tb/tb_cmos_rgb565_pack.sv
`timescale 1ns/1ps
module tb_cmos_rgb565_pack;

  localparam int unsigned SKIP = 2;
  localparam bit          POL  = 1'b1;
  localparam int unsigned HP   = 1024;
  localparam int unsigned FW   = 8;
  localparam int unsigned FMAX = (1 << FW) - 1;

`ifdef CMOS_PACK_TESTPAT_EN
  localparam logic [15:0] LIT0    = 16'hFFFF;
  localparam logic [15:0] LIT1    = 16'hFFFF;
  localparam logic [15:0] LIT128  = 16'hFFE0;
  localparam logic [15:0] LIT1023 = 16'h0000;
`else
  localparam logic [15:0] LIT0    = 16'hABCD;
  localparam logic [15:0] LIT1    = 16'hAEC8;
  localparam logic [15:0] LIT128  = 16'h2B4D;
  localparam logic [15:0] LIT1023 = 16'hA8D2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          sec_tick;
  logic          frame_valid;
  logic          frame_start;
  logic          line_err;
  logic [FW-1:0] fps;

  cmos_rgb565_pack_if bus ();

  cmos_rgb565_pack #(
    .SKIP_FRAMES (SKIP),
    .VSYNC_POL   (POL),
    .H_PIXELS    (HP),
    .FPS_W       (FW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .sec_tick    (sec_tick),
    .cam         (bus.slave),
    .frame_valid (frame_valid),
    .frame_start (frame_start),
    .line_err    (line_err),
    .fps         (fps)
  );

  always #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- model ----------------
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit          m_init;
  int unsigned m_nb;     // boundaries since init_done rose
  int unsigned m_cnt;    // frames this second
  int unsigned m_fps;
  bit          m_le;
  int unsigned m_fs = 0;

  typedef struct {
    logic [15:0] data;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ce;
  logic [15:0] seen[$];
  int unsigned we_cnt = 0;
  int unsigned fs_cnt = 0;
  int unsigned first_lo_cyc = 0;
  int unsigned first_we_cyc = 0;

  function automatic bit m_active();
    return m_init && (m_nb > SKIP);
  endfunction

  function automatic logic [7:0] pix_hi(input int unsigned line, input int unsigned i);
    return 8'(i * 3 + line * 17 + 171);
  endfunction

  function automatic logic [7:0] pix_lo(input int unsigned line, input int unsigned i);
    return 8'(205 - i * 5 - line);
  endfunction

  function automatic logic [15:0] exp_word(input int unsigned line, input int unsigned i);
`ifdef CMOS_PACK_TESTPAT_EN
    logic [15:0] bars [0:7];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return bars[(i * 8 / HP) % 8];
`else
    return {pix_hi(line, i), pix_lo(line, i)};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (bus.pix_we === 1'b1) begin
      we_cnt++;
      seen.push_back(bus.pix_data);
      if (first_we_cyc == 0) first_we_cyc = cyc_n;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pix_we: got strobe with data %h, expected no strobe (cycle %0d)",
                 bus.pix_data, cyc_n);
      end else begin
        ce = exp_q.pop_front();
        check("pix_data", bus.pix_data, ce.data);
        check("pix_we_cycle", cyc_n, ce.due);
      end
    end
    if (frame_start === 1'b1) fs_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst            = 1'b1;
    init_done      = 1'b0;
    sec_tick       = 1'b0;
    bus.cmos_vsync = ~POL;
    bus.cmos_href  = 1'b0;
    bus.cmos_d     = '0;
    cyc(3);
    m_init = 0; m_nb = 0; m_cnt = 0; m_fps = 0; m_le = 0;
    check("rst_pix_we", bus.pix_we, 0);
    check("rst_pix_data", bus.pix_data, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_line_err", line_err, 0);
    check("rst_fps", fps, 0);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic set_init(input bit v);
    init_done = v;
    m_init    = v;
    if (!v) m_nb = 0;
    cyc(2);
  endtask

  task automatic frame_boundary(input bit with_tick);
    bus.cmos_vsync = POL;
    cyc(3);
    bus.cmos_vsync = ~POL;
    cyc(1);
    if (with_tick) sec_tick = 1'b1;
    cyc(1);
    sec_tick = 1'b0;
    if (m_init) begin
      m_nb++;
      if (m_active()) m_fs++;
      if (m_cnt < FMAX) m_cnt++;
    end
    if (with_tick) begin
      m_fps = m_cnt;
      m_cnt = 0;
    end
    cyc(3);
    check("frame_valid", frame_valid, m_active());
    check("fps", fps, m_fps);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cyc(1);
    sec_tick = 1'b0;
    m_fps = m_cnt;
    m_cnt = 0;
    cyc(1);
    check("fps_tick", fps, m_fps);
  endtask

  task automatic send_line(input int unsigned line, input int unsigned npix, input bit odd);
    bit act;
    act = m_active();
    for (int unsigned i = 0; i < npix; i++) begin
      bus.cmos_href = 1'b1;
      bus.cmos_d    = pix_hi(line, i);
      cyc(1);
      bus.cmos_d    = pix_lo(line, i);
      if (act) begin
        if (first_lo_cyc == 0) first_lo_cyc = cyc_n;
        exp_q.push_back('{exp_word(line, i), cyc_n + 2});
      end
      cyc(1);
    end
    if (odd) begin
      bus.cmos_d = 8'h5A;
      cyc(1);
    end
    bus.cmos_href = 1'b0;
    bus.cmos_d    = '0;
    if (act && ((npix != HP) || odd)) m_le = 1;
    cyc(4);
  endtask

  int unsigned w0;

  initial begin
    do_reset();

    // boundaries before init_done are not counted
    frame_boundary(0);
    tick();
    check("fps_pre_init", fps, 0);

    // warm-up skip and first active frames
    set_init(1);
    frame_boundary(0);
    send_line(0, HP, 0);
    send_line(1, HP, 0);
    frame_boundary(0);
    send_line(0, HP, 0);
    send_line(1, HP, 0);
    check("we_during_skip", we_cnt, 0);
    check("fv_before_b3", frame_valid, 0);
    frame_boundary(0);
    check("fv_at_b3", frame_valid, 1);
    w0 = we_cnt;
    send_line(0, HP, 0);
    send_line(1, HP, 0);
    check("we_frame3", we_cnt - w0, 2048);
    check("word_0", seen[0], LIT0);
    check("word_1", seen[1], LIT1);
    check("word_128", seen[128], LIT128);
    check("word_1023", seen[1023], LIT1023);
    check("abcd_latency", first_we_cyc - first_lo_cyc, 2);
    frame_boundary(0);
    send_line(0, HP, 0);
    send_line(1, HP, 0);
    check("line_err_good", line_err, m_le);
    check("line_err_good_lit", line_err, 0);
    check("frame_start_count", fs_cnt, m_fs);

    // short line sets sticky error
    send_line(0, HP - 1, 0);
    check("line_err_1023", line_err, 1);
    frame_boundary(0);
    send_line(0, HP, 0);
    frame_boundary(0);
    check("line_err_sticky", line_err, m_le);

    // init_done drops with one byte of a pair held
    bus.cmos_href = 1'b1;
    bus.cmos_d    = 8'h11;
    cyc(1);
    bus.cmos_d    = 8'h22;
    cyc(1);
    init_done = 1'b0;
    m_init    = 0;
    m_nb      = 0;
    bus.cmos_d = 8'h33;
    cyc(1);
    check("fv_drop", frame_valid, 0);
    bus.cmos_href = 1'b0;
    bus.cmos_d    = '0;
    cyc(6);
    frame_boundary(0);
    set_init(1);
    frame_boundary(0);
    frame_boundary(0);
    check("fv_reskip", frame_valid, 0);
    frame_boundary(0);
    check("fv_reactive", frame_valid, 1);
    check("line_err_after_reinit", line_err, 1);

    // fps: 30 boundaries plus one coincident with the tick
    tick();
    for (int k = 0; k < 30; k++) frame_boundary(0);
    frame_boundary(1);
    check("fps_31", fps, 31);
    tick();
    check("fps_next_zero", fps, 0);
    for (int k = 0; k < 300; k++) frame_boundary(0);
    tick();
    check("fps_saturate", fps, FMAX);

    // reset clears sticky error; 2047-byte line
    do_reset();
    set_init(1);
    repeat (3) frame_boundary(0);
    send_line(0, HP - 1, 1);
    check("line_err_2047B", line_err, 1);
    frame_boundary(0);
    send_line(0, HP, 0);
    check("line_err_2047B_sticky", line_err, m_le);

    // full pixel count but trailing odd byte
    do_reset();
    set_init(1);
    repeat (3) frame_boundary(0);
    send_line(0, HP, 1);
    check("line_err_odd", line_err, 1);

    cyc(4);
    check("exp_q_drained", exp_q.size(), 0);
    check("frame_start_total", fs_cnt, m_fs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
